// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC rotator.
// Angles are Q2.14 radians before scaling to the datapath width.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ITER = 8;

  function automatic logic [15:0] atan_q14(
    input logic [2:0] idx
  );
    atan_q14 = '0;
    unique case (idx)
      3'd0: atan_q14 = 16'd12868;
      3'd1: atan_q14 = 16'd7596;
      3'd2: atan_q14 = 16'd4014;
      3'd3: atan_q14 = 16'd2037;
      3'd4: atan_q14 = 16'd1023;
      3'd5: atan_q14 = 16'd512;
      3'd6: atan_q14 = 16'd256;
      3'd7: atan_q14 = 16'd128;
    endcase
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Arctangent lookup for one micro-rotation step.
// Q2.14 table entries are promoted to the datapath's Q2.(WIDTH-2).
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       idx,
  output logic [WIDTH-1:0] angle
);

  logic [WIDTH-1:0] base;

  assign base  = WIDTH'(atan_q14(idx));
  assign angle = base << (WIDTH - 16);

endmodule

// File: rtl/cordic_iter_rotator.sv
// Rotation-mode CORDIC: one shift-add micro-rotation per clock,
// eight iterations per start, result held until the next completion.
module cordic_iter_rotator
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [WIDTH-1:0] z_in,
  output logic                    busy,
  output logic                    done,
  output logic [2:0]              iter,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out,
  output logic signed [WIDTH-1:0] z_out
);

  state_t state, state_next;
  logic   load, run, last, neg;
  logic [2:0] iter_cnt;

  logic signed [WIDTH-1:0] x_acc, y_acc, z_acc;
  logic signed [WIDTH-1:0] x_next, y_next, z_next;
  logic signed [WIDTH-1:0] x_sh, y_sh;
  logic [WIDTH-1:0]        angle;

  cordic_atan_rom #(.WIDTH(WIDTH)) u_rom (
    .idx   (iter_cnt),
    .angle (angle)
  );

  assign run  = state == RUN;
  assign last = iter_cnt == 3'(ITER - 1);
  assign neg  = z_acc[WIDTH-1];
  assign x_sh = x_acc >>> iter_cnt;
  assign y_sh = y_acc >>> iter_cnt;

  // Direction follows the sign of the residual angle.
  always_comb begin
    x_next = x_acc - y_sh;
    y_next = y_acc + x_sh;
    z_next = z_acc - $signed(angle);
    if (neg) begin
      x_next = x_acc + y_sh;
      y_next = y_acc - x_sh;
      z_next = z_acc + $signed(angle);
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      iter_cnt <= '0;
      x_acc    <= '0;
      y_acc    <= '0;
      z_acc    <= '0;
      x_out    <= '0;
      y_out    <= '0;
      z_out    <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        x_acc    <= x_in;
        y_acc    <= y_in;
        z_acc    <= z_in;
        iter_cnt <= '0;
      end else if (run) begin
        x_acc    <= x_next;
        y_acc    <= y_next;
        z_acc    <= z_next;
        // Wraps 7 -> 0 on the terminal step.
        iter_cnt <= iter_cnt + 3'd1;
      end
      if (run && last) begin
        x_out <= x_next;
        y_out <= y_next;
        z_out <= z_next;
      end
    end
  end

  assign busy = run;
  assign done = state == DONE;
  assign iter = iter_cnt;

endmodule

// File: tb/tb_cordic_iter_rotator.sv
// Scoreboard bench for cordic_iter_rotator with a
// plain-arithmetic CORDIC reference model.
module tb_cordic_iter_rotator;

  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic reset, start;
  logic signed [WIDTH-1:0] x_in, y_in, z_in;
  logic busy, done;
  logic [2:0] iter;
  logic signed [WIDTH-1:0] x_out, y_out, z_out;

  typedef struct {
    int x;
    int y;
    int z;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   atan_tab[8] = '{12868, 7596, 4014, 2037,
                        1023, 512, 256, 128};

  cordic_iter_rotator #(.WIDTH(WIDTH)) dut (
    .clock (clk),
    .reset (reset),
    .start (start),
    .x_in  (x_in),
    .y_in  (y_in),
    .z_in  (z_in),
    .busy  (busy),
    .done  (done),
    .iter  (iter),
    .x_out (x_out),
    .y_out (y_out),
    .z_out (z_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic int w16(int v);
    return int'(shortint'(v));
  endfunction

  // Rotate by the residual angle's sign, eight steps.
  function automatic exp_t model(int x0, int y0, int z0);
    exp_t e;
    int x = x0;
    int y = y0;
    int z = z0;
    int nx, ny;
    for (int i = 0; i < 8; i++) begin
      if (z >= 0) begin
        nx = x - (y >>> i);
        ny = y + (x >>> i);
        z  = z - atan_tab[i];
      end else begin
        nx = x + (y >>> i);
        ny = y - (x >>> i);
        z  = z + atan_tab[i];
      end
      x = w16(nx);
      y = w16(ny);
      z = w16(z);
    end
    e.x = x;
    e.y = y;
    e.z = z;
    e.cyc = 0;
    return e;
  endfunction

  task automatic check(string name, int act, int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d",
               name, act, req);
    end
  endtask

  task automatic near(string name, int act, int tgt,
                      int tol);
    n_checks++;
    if (act > tgt + tol || act < tgt - tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d",
               name, act, tgt, tol);
    end
  endtask

  // Monitor: pop and compare on every done pulse.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("x_out", int'(x_out), e.x);
        check("y_out", int'(y_out), e.y);
        check("z_out", int'(z_out), e.z);
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(int x, int y, int z);
    exp_t e;
    start = 1'b1;
    x_in  = WIDTH'(x);
    y_in  = WIDTH'(y);
    z_in  = WIDTH'(z);
    e = model(x, y, z);
    e.cyc = cyc + 9;
    sb.push_back(e);
    tick();
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_iter"}, int'(iter), 0);
    check({tag, "_x"}, int'(x_out), 0);
    check({tag, "_y"}, int'(y_out), 0);
    check({tag, "_z"}, int'(z_out), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rx, ry, rz;
    reset = 1'b1;
    start = 1'b1;
    x_in  = 16'sd1000;
    y_in  = 16'sd1000;
    z_in  = 16'sd1000;
    tick();
    tick();
    check_zero("reset");
    reset = 1'b0;
    start = 1'b0;
    tick();

    issue(9949, 0, 0);
    drain();
    near("cos0_x", int'(x_out), 16384, 150);
    near("cos0_y", int'(y_out), 0, 150);

    tick();
    issue(9949, 0, 12868);
    drain();
    near("pi4_x", int'(x_out), 11585, 150);
    near("pi4_y", int'(y_out), 11585, 150);

    tick();
    issue(9949, 0, -12868);
    repeat (8) tick();
    check("neg_done", int'(done), 1);
    near("neg_y", int'(y_out), -11585, 150);
    issue(9949, 0, 0);
    drain();

    // Start pulse mid-run must be ignored.
    tick();
    issue(8000, 3000, 5000);
    tick();
    tick();
    check("run_iter", int'(iter), 2);
    check("run_busy", int'(busy), 1);
    start = 1'b1;
    x_in  = 16'sd100;
    y_in  = -16'sd100;
    z_in  = -16'sd9000;
    tick();
    start = 1'b0;
    drain();
    repeat (12) tick();

    // Reset in the middle of a run.
    issue(9949, 0, 12868);
    repeat (3) tick();
    reset = 1'b1;
    sb.delete();
    tick();
    check_zero("midreset");
    reset = 1'b0;
    repeat (12) tick();
    issue(9949, 0, 0);
    drain();

    // Randomized runs, some back-to-back.
    for (int t = 0; t < 12; t++) begin
      rx = int'($urandom_range(26000)) - 13000;
      ry = int'($urandom_range(26000)) - 13000;
      rz = int'($urandom_range(51470)) - 25735;
      issue(rx, ry, rz);
      if (t % 3 == 2) begin
        drain();
        tick();
      end else begin
        repeat (8) tick();
      end
    end
    drain();
    repeat (12) tick();
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_iter_rotator.md
# cordic_iter_rotator

Iterative rotation-mode CORDIC engine that consumes a 3-bit iteration index and applies one shift-add micro-rotation per clock. It loads a vector (x, y) and an angle z on a start pulse and runs 8 iterations. It then presents the rotated vector with a one-cycle done pulse. It sits downstream of the iteration-index counting in the CORDIC datapath and owns its own index, with enable and terminal handling.

## Interface
- WIDTH, 16, two's-complement width of x, y, z (legal: ≥16)
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only when idle or done
- x_in  in  WIDTH  signed initial x
- y_in  in  WIDTH  signed initial y
- z_in  in  WIDTH  signed angle, radians Q2.(WIDTH-2)
- busy  out  1  high while iterating
- done  out  1  one-cycle pulse, result valid
- iter  out  3  current iteration index
- x_out  out  WIDTH  rotated x (gain K≈1.6468 uncompensated)
- y_out  out  WIDTH  rotated y
- z_out  out  WIDTH  residual angle

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE, all outputs 0.
- IDLE/DONE with start=1: load x, y, z; iter←0; → RUN. Start while in RUN is ignored.
- RUN, each edge, with i = iter and d = +1 if z ≥ 0, else −1:
  - x ← x − d·(y >>> i)
  - y ← y + d·(x >>> i)
  - z ← z − d·atan(i)
  - iter ← iter+1
- Terminal: the edge processing i=7 wraps iter to 0, enters DONE and updates x_out/y_out/z_out.
- DONE lasts one cycle (done=1), then → IDLE unless start is high.
- Shifts are arithmetic. Add/sub wraps modulo 2^WIDTH with no saturation. Caller keeps |vector| ≤ 0.6·2^(WIDTH−1) and |z_in| ≤ π/2.
- atan(i) table, Q2.14, left-shifted by WIDTH−16: 12868, 7596, 4014, 2037, 1023, 512, 256, 128.
- x_out/y_out/z_out hold the last result until the next completion. They do not change during RUN.

## Timing
- start sampled at edge E0 → busy=1 from E0 through E8.
- Iterations occur at edges E1..E8. done=1 and outputs valid in the cycle after E8.
- Latency from start edge to done is 9 cycles.
- Back-to-back: start high during the DONE cycle reloads with no IDLE bubble. done then pulses every 9 cycles.
- iter is 0 in IDLE/DONE and equals the index being applied during RUN.
- Reset mid-RUN: next cycle is IDLE, busy=0, no done, outputs 0.
- Reset has priority over start.

## Structure
- cordic_pkg holds:
  - state encoding (IDLE/RUN/DONE)
  - ITER=8
  - the Q2.14 atan constants
- One sub-module, cordic_atan_rom: 3-bit index in, WIDTH-bit angle out. Combinational, scaled by WIDTH.
- The index counter stays internal (enable, terminal detect at 7, clear on load).

## Test plan
- Reset: assert reset 2 cycles with start=1 → busy=0, done=0, iter=0, x_out=y_out=z_out=0.
- cos/sin 0: x_in=9949, y_in=0, z_in=0 → done in cycle 9. Require:
  - x_out within 16384±150
  - |y_out| ≤ 150
  - bit-exact vs. the bench model
- π/4: x_in=9949, y_in=0, z_in=12868 → x_out and y_out both within 11585±150, bit-exact vs. model.
- Negative angle: z_in=−12868 → y_out within −11585±150. Then back-to-back start in the DONE cycle with z_in=0 → second done exactly 9 cycles after the first.
- Start ignored: pulse start at E3 with different inputs → first result unchanged, single done at cycle 9.
- Reset mid-operation: reset at E4 → no done, outputs 0. A fresh start afterwards completes normally in 9 cycles.
